// File: rtl/revenantx86_tinytpu.sv
// revenantx86_tinytpu: 2x2 output-stationary systolic matrix multiplier,
// C = A * B on signed 8-bit operands, with byte-wide result readback.
//
// Ports:
//   clk     : clock, all logic on its rising edge
//   rst_n   : synchronous reset, active HIGH (name kept from the harness)
//   ena     : command-accept enable (a running pass continues when low)
//   ui_in   : operand data byte (two's complement)
//   uio_in  : [2:0] opcode, [4:3] addr, [7:5] ignored
//   uo_out  : selected result byte of R[addr]
//   uio_out : [7] busy, [6] done, [5] sat, [4:0] zero
//   uio_oe  : constant 8'hE0
//
// Build option: define TINYTPU_SAT_EN to clamp readout to the int16 range;
// without it the readout is the low 16 bits of the accumulator (wraps).
//
// Handshake: there is none beyond the opcode. A command is taken on any
// rising edge with ena=1; while busy, LOAD_A/LOAD_B/START/CLEAR are dropped
// (START is also taken on the final compute edge and restarts the pass),
// SEL_LO/SEL_HI are always taken. busy in uio_out[7] mirrors the FSM state.
module revenantx86_tinytpu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [2:0] OP_LOAD_A = 3'b001;
  localparam logic [2:0] OP_LOAD_B = 3'b010;
  localparam logic [2:0] OP_START  = 3'b011;
  localparam logic [2:0] OP_SEL_LO = 3'b100;
  localparam logic [2:0] OP_SEL_HI = 3'b101;
  localparam logic [2:0] OP_CLEAR  = 3'b110;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             state;
  logic [1:0]         step;
  logic signed [7:0]  a_m [4];
  logic signed [7:0]  b_m [4];
  logic signed [16:0] c_m [4];
  logic signed [7:0]  a_reg [2];   // A operand passed PE(i,0) -> PE(i,1)
  logic signed [7:0]  b_reg [2];   // B operand passed PE(0,j) -> PE(1,j)
  logic [2:0]         rp;
  logic               done;
  logic               sat;

  logic [2:0] op;
  logic [1:0] addr;
  logic       busy;
  logic       last;
  logic       unused_bits;

  assign op          = uio_in[2:0];
  assign addr        = uio_in[4:3];
  assign unused_bits = ^uio_in[7:5];
  assign busy        = (state == ST_RUN);
  assign last        = busy && (step == 2'd3);

  // Skewed edge feeds: row i of A enters i cycles late, column j of B j
  // cycles late; zero outside the active window so late PEs add nothing.
  logic signed [7:0] a_feed [2];
  logic signed [7:0] b_feed [2];
  always_comb begin
    a_feed[0] = (step == 2'd0) ? a_m[0] : (step == 2'd1) ? a_m[1] : 8'sd0;
    a_feed[1] = (step == 2'd1) ? a_m[2] : (step == 2'd2) ? a_m[3] : 8'sd0;
    b_feed[0] = (step == 2'd0) ? b_m[0] : (step == 2'd1) ? b_m[2] : 8'sd0;
    b_feed[1] = (step == 2'd1) ? b_m[1] : (step == 2'd2) ? b_m[3] : 8'sd0;
  end

  // PE index p = 2*row + col.
  logic signed [7:0]  op_a [4];
  logic signed [7:0]  op_b [4];
  logic signed [15:0] prod [4];
  logic signed [16:0] c_next [4];
  logic [3:0]         ovf;

  always_comb begin
    op_a[0] = a_feed[0];
    op_a[1] = a_reg[0];
    op_a[2] = a_feed[1];
    op_a[3] = a_reg[1];
    op_b[0] = b_feed[0];
    op_b[1] = b_feed[1];
    op_b[2] = b_reg[0];
    op_b[3] = b_reg[1];
  end

  for (genvar p = 0; p < 4; p++) begin : g_pe
    assign prod[p]   = op_a[p] * op_b[p];
    assign c_next[p] = c_m[p] + {prod[p][15], prod[p]};
    // Outside int16 exactly when the two top bits of the 17-bit sum differ.
    assign ovf[p]    = c_next[p][16] ^ c_next[p][15];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= ST_IDLE;
      step  <= 2'd0;
      rp    <= 3'd0;
      done  <= 1'b0;
      sat   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_m[i] <= 8'sd0;
        b_m[i] <= 8'sd0;
        c_m[i] <= 17'sd0;
      end
      for (int i = 0; i < 2; i++) begin
        a_reg[i] <= 8'sd0;
        b_reg[i] <= 8'sd0;
      end
    end else begin
      if (busy) begin
        for (int i = 0; i < 4; i++) c_m[i] <= c_next[i];
        a_reg[0] <= a_feed[0];
        a_reg[1] <= a_feed[1];
        b_reg[0] <= b_feed[0];
        b_reg[1] <= b_feed[1];
        step     <= step + 2'd1;
        if (last) begin
          state <= ST_IDLE;
          done  <= 1'b1;
          sat   <= |ovf;
        end
      end
      // Commands come after the pass update so a restart on the final
      // edge overrides the completion assignments.
      if (ena) begin
        case (op)
          OP_LOAD_A: if (!busy) a_m[addr] <= ui_in;
          OP_LOAD_B: if (!busy) b_m[addr] <= ui_in;
          OP_START: begin
            if (!busy || last) begin
              state <= ST_RUN;
              step  <= 2'd0;
              done  <= 1'b0;
              sat   <= 1'b0;
              for (int i = 0; i < 4; i++) c_m[i] <= 17'sd0;
              for (int i = 0; i < 2; i++) begin
                a_reg[i] <= 8'sd0;
                b_reg[i] <= 8'sd0;
              end
            end
          end
          OP_SEL_LO: rp <= {addr, 1'b0};
          OP_SEL_HI: rp <= {addr, 1'b1};
          OP_CLEAR: begin
            if (!busy) begin
              done <= 1'b0;
              sat  <= 1'b0;
              for (int i = 0; i < 4; i++) begin
                a_m[i] <= 8'sd0;
                b_m[i] <= 8'sd0;
                c_m[i] <= 17'sd0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Readout path, combinational from registers.
  logic signed [16:0] c_sel;
  logic [15:0]        r_val;
  always_comb begin
    c_sel = c_m[rp[2:1]];
`ifdef TINYTPU_SAT_EN
    if (c_sel[16] != c_sel[15]) r_val = c_sel[16] ? 16'h8000 : 16'h7FFF;
    else                        r_val = c_sel[15:0];
`else
    r_val = c_sel[15:0];
`endif
  end

  assign uo_out  = rp[0] ? r_val[15:8] : r_val[7:0];
  assign uio_out = {busy, done, sat, 5'b00000};
  assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_revenantx86_tinytpu.sv
module tb_revenantx86_tinytpu;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LOAD_A = 3'b001;
  localparam logic [2:0] OP_LOAD_B = 3'b010;
  localparam logic [2:0] OP_START  = 3'b011;
  localparam logic [2:0] OP_SEL_LO = 3'b100;
  localparam logic [2:0] OP_SEL_HI = 3'b101;
  localparam logic [2:0] OP_CLEAR  = 3'b110;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;

  // Reference model: matrices as plain integers.
  byte ma [4];
  byte mb [4];
  int  mc [4];
  bit  m_sat;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  revenantx86_tinytpu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      ma[i] = 0;
      mb[i] = 0;
      mc[i] = 0;
    end
    m_sat = 1'b0;
  endtask

  task automatic model_compute();
    m_sat = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        mc[2*i+j] = int'(ma[2*i]) * int'(mb[j]) + int'(ma[2*i+1]) * int'(mb[2+j]);
        if (mc[2*i+j] > 32767 || mc[2*i+j] < -32768) m_sat = 1'b1;
      end
  endtask

  function automatic logic [7:0] exp_byte(input int a, input bit hi);
    int c;
    logic [15:0] r;
    c = mc[a];
`ifdef TINYTPU_SAT_EN
    if (c > 32767)       r = 16'h7FFF;
    else if (c < -32768) r = 16'h8000;
    else                 r = c[15:0];
`else
    r = c[15:0];
`endif
    return hi ? r[15:8] : r[7:0];
  endfunction

  // ---------------- drivers ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [7:0] d, input bit en);
    ui_in  = d;
    uio_in = {3'b000, a, op};
    ena    = en;
    @(posedge clk); #1;
    uio_in = {5'b00000, OP_NOP};
    ena    = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_clear();
  endtask

  task automatic load_mats(input byte a[4], input byte b[4]);
    for (int i = 0; i < 4; i++) begin
      issue(OP_LOAD_A, 2'(i), a[i], 1'b1);
      ma[i] = a[i];
      issue(OP_LOAD_B, 2'(i), b[i], 1'b1);
      mb[i] = b[i];
    end
  endtask

  // START, then busy must be seen after exactly four edges, then done/sat.
  task automatic run_pass(input string tag);
    issue(OP_START, 2'd0, 8'h00, 1'b1);
    model_compute();
    check({tag, "_busy0"}, 32'(uio_out[7]), 32'd1);
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
      check({tag, "_busy"}, 32'(uio_out[7]), 32'd1);
    end
    @(posedge clk); #1;
    check({tag, "_flags"}, 32'(uio_out), 32'({1'b0, 1'b1, m_sat, 5'b0}));
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < 4; a++) begin
      issue(OP_SEL_LO, 2'(a), 8'h00, 1'b1);
      check({tag, "_lo"}, 32'(uo_out), 32'(exp_byte(a, 1'b0)));
      issue(OP_SEL_HI, 2'(a), 8'h00, 1'b1);
      check({tag, "_hi"}, 32'(uo_out), 32'(exp_byte(a, 1'b1)));
    end
  endtask

  // ---------------- stimulus ----------------
  byte ta [4];
  byte tb_b [4];

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 3; i++) begin
      check("rst_uo", 32'(uo_out), 32'h00);
      check("rst_uio", 32'(uio_out), 32'h00);
      check("rst_oe", 32'(uio_oe), 32'hE0);
      idle(1);
    end

    // Basic multiply.
    ta = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    tb_b = '{8'sd5, 8'sd6, 8'sd7, 8'sd8};
    load_mats(ta, tb_b);
    run_pass("basic");
    check("basic_model_c00", 32'(mc[0]), 32'd19);
    readback("basic");

    // Negative operands.
    ta = '{-8'sd1, 8'sd0, 8'sd0, -8'sd1};
    tb_b = '{8'sd3, 8'sd4, 8'sd5, 8'sd6};
    load_mats(ta, tb_b);
    run_pass("neg");
    readback("neg");

    // Saturation corner: every element -128 gives 32768 in each C.
    ta = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
    tb_b = ta;
    load_mats(ta, tb_b);
    run_pass("sat");
    check("sat_flag", 32'(uio_out[5]), 32'd1);
    readback("sat");

    // Busy lockout: LOAD_A and CLEAR dropped, SEL_HI honoured.
    ta = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    tb_b = '{8'sd5, 8'sd6, 8'sd7, 8'sd8};
    load_mats(ta, tb_b);
    issue(OP_START, 2'd0, 8'h00, 1'b1);
    model_compute();
    issue(OP_LOAD_A, 2'd0, 8'h7F, 1'b1);
    issue(OP_CLEAR, 2'd0, 8'h00, 1'b1);
    issue(OP_SEL_HI, 2'd2, 8'h00, 1'b1);
    idle(1);
    check("lock_flags", 32'(uio_out), 32'h40);
    check("lock_selhi", 32'(uo_out), 32'(exp_byte(2, 1'b1)));
    run_pass("lock_rerun");
    readback("lock");

    // Reset in the middle of a pass.
    issue(OP_START, 2'd0, 8'h00, 1'b1);
    idle(1);
    do_reset();
    check("midrst_uio", 32'(uio_out), 32'h00);
    check("midrst_uo", 32'(uo_out), 32'h00);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("midrst_nodone", 32'(uio_out), 32'h00);
    end
    readback("midrst");

    // ena=0: loads and START have no effect.
    issue(OP_LOAD_A, 2'd0, 8'h55, 1'b0);
    issue(OP_LOAD_B, 2'd0, 8'h33, 1'b0);
    issue(OP_START, 2'd0, 8'h00, 1'b0);
    check("ena0_nobusy", 32'(uio_out), 32'h00);
    idle(4);
    check("ena0_nodone", 32'(uio_out), 32'h00);
    run_pass("ena0");
    readback("ena0");

    // Randomized passes, with an occasional CLEAR.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 4; i++) begin
        ta[i]   = byte'($urandom_range(0, 255));
        tb_b[i] = byte'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 4) == 0) begin
        ta[0] = -8'sd128; ta[1] = -8'sd128;
        tb_b[0] = -8'sd128; tb_b[2] = -8'sd128;
      end
      load_mats(ta, tb_b);
      run_pass("rnd");
      readback("rnd");
      if ($urandom_range(0, 3) == 0) begin
        issue(OP_CLEAR, 2'd0, 8'h00, 1'b1);
        model_clear();
        check("clr_flags", 32'(uio_out), 32'h00);
        readback("clr");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit.
  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
